// File: rtl/uart_brg.sv
// UART baud rate generator: SPBRG register, 16x sample strobe, bit strobe, RX phase resync.
// Define UART_BRG_ABD_EN to build the auto-baud measurement of a received 0x55.
module uart_brg #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned LO_DIV     = 4,
    parameter int unsigned ABD_CNT_W  = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] reg_data_in,
    input  logic       spbrg_reg_wr_en,
    output logic [7:0] spbrg_reg_out,
    input  logic       brgh,
    input  logic       brg_en,
    input  logic       rx_resync,
    output logic       sample_tick,
    output logic       bit_tick,
    output logic [3:0] bit_phase,
    input  logic       UART_RXD,
    input  logic       abd_start,
    output logic       abd_busy,
    output logic       abd_done,
    output logic       abd_ovf
);

    localparam int unsigned PRE_W = (LO_DIV > 1) ? $clog2(LO_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(LO_DIV - 1);
    localparam logic [3:0] PH_MAX = 4'(OVERSAMPLE - 1);

    logic [7:0]       spbrg_q, spbrg_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [7:0]       brg_q, brg_d;
    logic [3:0]       phase_q, phase_d;
    logic             stick_q, stick_d;
    logic             btick_q, btick_d;

    logic             abd_hold;
    logic             abd_load;
    logic [7:0]       abd_val;

    always_comb begin
        spbrg_d = spbrg_q;
        pre_d   = pre_q;
        brg_d   = brg_q;
        phase_d = phase_q;
        stick_d = 1'b0;
        btick_d = 1'b0;
        if (spbrg_reg_wr_en) begin
            spbrg_d = reg_data_in;
            pre_d   = '0;
            brg_d   = reg_data_in;
            phase_d = 4'd0;
        end else if (abd_load) begin
            spbrg_d = abd_val;
            pre_d   = '0;
            brg_d   = abd_val;
            phase_d = 4'd0;
        end else if (rx_resync || !brg_en || abd_hold) begin
            // Preloading the divider makes the first tick land one full period after restart.
            pre_d   = '0;
            brg_d   = spbrg_q;
            phase_d = 4'd0;
        end else if (brgh || (pre_q == PRE_MAX)) begin
            pre_d = '0;
            if (brg_q == 8'd0) begin
                brg_d   = spbrg_q;
                stick_d = 1'b1;
                btick_d = (phase_q == PH_MAX);
                phase_d = (phase_q == PH_MAX) ? 4'd0 : phase_q + 4'd1;
            end else begin
                brg_d = brg_q - 8'd1;
            end
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spbrg_q <= 8'd0;
            pre_q   <= '0;
            brg_q   <= 8'd0;
            phase_q <= 4'd0;
            stick_q <= 1'b0;
            btick_q <= 1'b0;
        end else begin
            spbrg_q <= spbrg_d;
            pre_q   <= pre_d;
            brg_q   <= brg_d;
            phase_q <= phase_d;
            stick_q <= stick_d;
            btick_q <= btick_d;
        end
    end

    assign spbrg_reg_out = spbrg_q;
    assign sample_tick   = stick_q;
    assign bit_tick      = btick_q;
    assign bit_phase     = phase_q;

`ifdef UART_BRG_ABD_EN
    typedef enum logic [1:0] {StIdle, StWaitFall, StWaitRise, StMeasure} abd_state_e;

    localparam int unsigned SH_HI = $clog2(OVERSAMPLE * 8);
    localparam int unsigned SH_LO = $clog2(OVERSAMPLE * 8 * LO_DIV);

    abd_state_e           state_q, state_d;
    logic [ABD_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]           rise_q, rise_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;
    logic [1:0]           rxd_sync_q;
    logic                 rxd_prev_q;
    logic                 rxd_rise, rxd_fall;
    logic [ABD_CNT_W-1:0] measured, quot;
    logic                 quot_ok;

    assign rxd_rise = rxd_sync_q[1] & ~rxd_prev_q;
    assign rxd_fall = ~rxd_sync_q[1] & rxd_prev_q;
    // The 5th rise is seen in the cycle where cnt_q has not yet counted itself.
    assign measured = cnt_q + ABD_CNT_W'(1);
    assign quot     = brgh ? (measured >> SH_HI) : (measured >> SH_LO);
    assign quot_ok  = (quot != '0) && (quot <= ABD_CNT_W'(256));
    assign abd_val  = 8'(quot - ABD_CNT_W'(1));
    assign abd_hold = (state_q != StIdle) || abd_start;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rise_d   = rise_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        abd_load = 1'b0;
        if (spbrg_reg_wr_en || !brg_en) begin
            state_d = StIdle;
        end else if (abd_start) begin
            ovf_d   = 1'b0;
            state_d = StWaitFall;
        end else begin
            case (state_q)
                StWaitFall: if (rxd_fall) state_d = StWaitRise;
                StWaitRise: begin
                    if (rxd_rise) begin
                        cnt_d   = '0;
                        rise_d  = 3'd1;
                        state_d = StMeasure;
                    end
                end
                StMeasure: begin
                    cnt_d = cnt_q + ABD_CNT_W'(1);
                    if (cnt_q == '1) begin
                        ovf_d   = 1'b1;
                        state_d = StIdle;
                    end else if (rxd_rise) begin
                        if (rise_q == 3'd4) begin
                            state_d = StIdle;
                            if (quot_ok) begin
                                abd_load = 1'b1;
                                done_d   = 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            rise_d = rise_q + 3'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rise_q     <= 3'd0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            rxd_sync_q <= 2'b11;
            rxd_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rise_q     <= rise_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            rxd_sync_q <= {rxd_sync_q[0], UART_RXD};
            rxd_prev_q <= rxd_sync_q[1];
        end
    end

    assign abd_busy = (state_q != StIdle);
    assign abd_done = done_q;
    assign abd_ovf  = ovf_q;
`else
    logic unused_abd;
    assign unused_abd = ^{UART_RXD, abd_start};
    assign abd_hold   = 1'b0;
    assign abd_load   = 1'b0;
    assign abd_val    = 8'h00;
    assign abd_busy   = 1'b0;
    assign abd_done   = 1'b0;
    assign abd_ovf    = 1'b0;
`endif

endmodule
